// File: rtl/game_progress_tracker_if.sv
// rtl/game_progress_tracker_if.sv - event/status bundle between game logic and the progress tracker
//
// Purpose: groups the game-event inputs and the HUD status outputs of
// game_progress_tracker into one port.
// Ports (slave = tracker side):
//   start, pause, brick_hit, ball_lost : game events / controls into the tracker
//   total_health                       : health total of the level being entered
//   state, health_left, lives_left,
//   level, level_clear, win, lose      : registered status out of the tracker
interface game_progress_tracker_if #(
  parameter int HEALTH_W = 10
);
  logic                start;
  logic                pause;
  logic                brick_hit;
  logic                ball_lost;
  logic [HEALTH_W-1:0] total_health;
  logic [2:0]          state;
  logic [HEALTH_W-1:0] health_left;
  logic [3:0]          lives_left;
  logic [3:0]          level;
  logic                level_clear;
  logic                win;
  logic                lose;

  modport master (
    output start, pause, brick_hit, ball_lost, total_health,
    input  state, health_left, lives_left, level, level_clear, win, lose
  );

  modport slave (
    input  start, pause, brick_hit, ball_lost, total_health,
    output state, health_left, lives_left, level, level_clear, win, lose
  );
endinterface

// File: rtl/game_progress_tracker.sv
// rtl/game_progress_tracker.sv - brick-breaker level/lives/health progress controller
//
// Purpose: counts down brick health per level, tracks lives and level index,
// and sequences IDLE -> PLAY -> CLEAR -> (PLAY | WIN), or PLAY -> LOSE.
// Ports:
//   clk    : clock
//   resetn : synchronous active-low reset
//   bus    : game_progress_tracker_if.slave (events in, registered status out)
module game_progress_tracker #(
  parameter int HEALTH_W     = 10,
  parameter int LEVELS       = 3,
  parameter int LIVES        = 3,
  parameter int CLEAR_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  game_progress_tracker_if.slave bus
);
  localparam int CNT_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_CLEAR = 3'd2,
    S_WIN   = 3'd3,
    S_LOSE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [HEALTH_W-1:0] health_q, health_d;
  logic [3:0]          lives_q, lives_d;
  logic [3:0]          level_q, level_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                lc_q, lc_d;
  logic                win_q, win_d;
  logic                lose_q, lose_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      health_q <= '0;
      lives_q  <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      lc_q     <= 1'b0;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      health_q <= health_d;
      lives_q  <= lives_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      lc_q     <= lc_d;
      win_q    <= win_d;
      lose_q   <= lose_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    health_d = health_q;
    lives_d  = lives_q;
    level_d  = level_q;
    cnt_d    = cnt_q;
    lc_d     = 1'b0;

    case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (bus.start) begin
          level_d  = '0;
          lives_d  = 4'(LIVES);
          health_d = bus.total_health;
          cnt_d    = '0;
          if (bus.total_health == '0) begin
            state_d = S_CLEAR;
            lc_d    = 1'b1;
          end else begin
            state_d = S_PLAY;
          end
        end
      end

      S_PLAY: begin
        if (!bus.pause) begin
          // The hit is resolved first; a clearing hit swallows a same-cycle ball loss.
          if (bus.brick_hit && health_q == HEALTH_W'(1)) begin
            health_d = '0;
            state_d  = S_CLEAR;
            lc_d     = 1'b1;
            cnt_d    = '0;
          end else begin
            if (bus.brick_hit && health_q > HEALTH_W'(1))
              health_d = health_q - HEALTH_W'(1);
            if (bus.ball_lost) begin
              if (lives_q > 4'd1) begin
                lives_d = lives_q - 4'd1;
              end else begin
                lives_d = '0;
                state_d = S_LOSE;
              end
            end
          end
        end
      end

      S_CLEAR: begin
        if (cnt_q == CNT_W'(CLEAR_CYCLES - 1)) begin
          cnt_d = '0;
          if (level_q == 4'(LEVELS - 1)) begin
            state_d = S_WIN;
          end else begin
            level_d  = level_q + 4'd1;
            health_d = bus.total_health;
            if (bus.total_health == '0) begin
              // Empty level: go straight through another CLEAR period.
              state_d = S_CLEAR;
              lc_d    = 1'b1;
            end else begin
              state_d = S_PLAY;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Registered from the next state so the flags rise together with state.
    win_d  = (state_d == S_WIN);
    lose_d = (state_d == S_LOSE);
  end

  assign bus.state       = state_q;
  assign bus.health_left = health_q;
  assign bus.lives_left  = lives_q;
  assign bus.level       = level_q;
  assign bus.level_clear = lc_q;
  assign bus.win         = win_q;
  assign bus.lose        = lose_q;
endmodule

// File: tb/tb_game_progress_tracker.sv
// tb/tb_game_progress_tracker.sv - scoreboard bench for game_progress_tracker
module tb_game_progress_tracker;
  localparam int I = 0, P = 1, C = 2, W = 3, L = 4;

  typedef struct packed {
    logic [2:0] st;
    logic [9:0] h;
    logic [3:0] lv;
    logic [3:0] lvl;
    logic       lc;
    logic       w;
    logic       lo;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  game_progress_tracker_if #(.HEALTH_W(10)) bus ();

  game_progress_tracker #(
    .HEALTH_W(10), .LEVELS(2), .LIVES(3), .CLEAR_CYCLES(4)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   nstep = 0;

  // Monitor: every clock edge the DUT presents a new status word; compare it
  // against the oldest expectation pushed by the stimulus.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp_t e;
        exp_t a;
        e = q.pop_front();
        a = '{st: bus.state, h: bus.health_left, lv: bus.lives_left, lvl: bus.level,
              lc: bus.level_clear, w: bus.win, lo: bus.lose};
        total++;
        nstep++;
        if (a !== e) begin
          bad++;
          $display("FAIL step%0d got st=%0d h=%0d lives=%0d lvl=%0d lc=%b win=%b lose=%b want st=%0d h=%0d lives=%0d lvl=%0d lc=%b win=%b lose=%b",
                   nstep, a.st, a.h, a.lv, a.lvl, a.lc, a.w, a.lo,
                   e.st, e.h, e.lv, e.lvl, e.lc, e.w, e.lo);
        end
      end
    end
  end

  // Drive one cycle of inputs and push the hand-computed post-edge status.
  task automatic s(input logic rn, input logic st, input logic ps, input logic hit,
                   input logic lost, input int th, input int es, input int eh,
                   input int elv, input int elvl, input logic elc, input logic ew,
                   input logic elo);
    exp_t e;
    @(negedge clk);
    resetn           = rn;
    bus.start        = st;
    bus.pause        = ps;
    bus.brick_hit    = hit;
    bus.ball_lost    = lost;
    bus.total_health = 10'(th);
    e.st  = 3'(es);
    e.h   = 10'(eh);
    e.lv  = 4'(elv);
    e.lvl = 4'(elvl);
    e.lc  = elc;
    e.w   = ew;
    e.lo  = elo;
    q.push_back(e);
  endtask

  initial begin
    resetn = 1'b0;
    bus.start = 1'b0; bus.pause = 1'b0; bus.brick_hit = 1'b0; bus.ball_lost = 1'b0;
    bus.total_health = '0;

    // reset state
    s(0,0,0,0,0,0, I,0,0,0,0,0,0);
    s(0,0,0,0,0,0, I,0,0,0,0,0,0);
    // level 0: three hits, CLEAR on the third
    s(1,1,0,0,0,3, P,3,3,0,0,0,0);
    s(1,0,0,1,0,3, P,2,3,0,0,0,0);
    s(1,0,0,1,0,3, P,1,3,0,0,0,0);
    s(1,0,0,1,0,3, C,0,3,0,1,0,0);
    for (int i = 0; i < 3; i++) s(1,0,0,1,1,2, C,0,3,0,0,0,0);
    s(1,0,0,0,0,2, P,2,3,1,0,0,0);
    // level 1: clearing hit with simultaneous loss keeps lives
    s(1,0,0,1,0,2, P,1,3,1,0,0,0);
    s(1,0,0,1,1,2, C,0,3,1,1,0,0);
    for (int i = 0; i < 3; i++) s(1,0,0,0,0,2, C,0,3,1,0,0,0);
    s(1,0,0,0,0,2, W,0,3,1,0,1,0);
    s(1,0,0,1,0,2, W,0,3,1,0,1,0);
    // restart from WIN, lose all lives
    s(1,1,0,0,0,3, P,3,3,0,0,0,0);
    s(1,0,0,0,1,3, P,3,2,0,0,0,0);
    s(1,0,0,0,1,3, P,3,1,0,0,0,0);
    s(1,0,0,0,1,3, L,3,0,0,0,0,1);
    s(1,0,0,1,0,3, L,3,0,0,0,0,1);
    // hit+lost with health 1 / lives 1, then with health 2 / lives 1
    s(1,1,0,0,0,1, P,1,3,0,0,0,0);
    s(1,0,0,0,1,1, P,1,2,0,0,0,0);
    s(1,0,0,0,1,1, P,1,1,0,0,0,0);
    s(1,0,0,1,1,2, C,0,1,0,1,0,0);
    for (int i = 0; i < 3; i++) s(1,0,0,0,0,2, C,0,1,0,0,0,0);
    s(1,0,0,0,0,2, P,2,1,1,0,0,0);
    s(1,0,0,1,1,2, L,1,0,1,0,0,1);
    // pause drops events; single hit after pause; start ignored in PLAY
    s(1,1,0,0,0,4, P,4,3,0,0,0,0);
    s(1,0,1,1,1,4, P,4,3,0,0,0,0);
    s(1,0,1,1,1,4, P,4,3,0,0,0,0);
    for (int i = 0; i < 3; i++) s(1,0,1,1,0,4, P,4,3,0,0,0,0);
    s(1,0,0,1,0,4, P,3,3,0,0,0,0);
    s(1,1,0,0,0,9, P,3,3,0,0,0,0);
    // zero-health start, reset mid-CLEAR
    s(0,0,0,0,0,0, I,0,0,0,0,0,0);
    s(1,1,0,0,0,0, C,0,3,0,1,0,0);
    s(1,0,0,0,0,0, C,0,3,0,0,0,0);
    s(0,0,0,0,0,0, I,0,0,0,0,0,0);
    // counter must restart from 0; empty level 1 re-enters CLEAR, then WIN
    s(1,1,0,0,0,0, C,0,3,0,1,0,0);
    for (int i = 0; i < 3; i++) s(1,0,0,0,0,0, C,0,3,0,0,0,0);
    s(1,0,0,0,0,0, C,0,3,1,1,0,0);
    for (int i = 0; i < 3; i++) s(1,0,0,0,0,0, C,0,3,1,0,0,0);
    s(1,0,0,0,0,0, W,0,3,1,0,1,0);

    // bounded drain of the scoreboard
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got pending=%0d want pending=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
